// File: rtl/spi_slave_pkg.sv
// Shared SPI responder definitions: word-length encoding, mode bit positions, FSM states.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package spi_slave_pkg;

  // word_len encoding
  localparam logic [1:0] LEN_8  = 2'b00;
  localparam logic [1:0] LEN_16 = 2'b01;
  localparam logic [1:0] LEN_24 = 2'b10;
  localparam logic [1:0] LEN_32 = 2'b11;

  // bit positions inside spi_mode {CPOL,CPHA}
  localparam int MODE_CPOL = 1;
  localparam int MODE_CPHA = 0;

  typedef enum logic [1:0] {
    IDLE_ARM = 2'd0,
    IDLE     = 2'd1,
    SHIFT    = 2'd2,
    HOLD     = 2'd3
  } state_t;

  // number of bits in a frame for a given word_len code
  function automatic logic [5:0] len_bits(input logic [1:0] word_len);
    logic [5:0] n;
    n = 6'd32;
    case (word_len)
      LEN_8:  n = 6'd8;
      LEN_16: n = 6'd16;
      LEN_24: n = 6'd24;
      LEN_32: n = 6'd32;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Multi-flop synchronizer bringing one asynchronous pin into the GCLK domain.
// Latency: STAGES GCLK cycles from pin to dout.
// Backpressure: none; samples every cycle.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic GCLK,
  input  logic RST,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_q;

  // shift the pin through the flop chain; reset to the idle level of the pin
  always_ff @(posedge GCLK) begin
    if (RST) sync_q <= {STAGES{RST_VAL}};
    else     sync_q <= {sync_q[STAGES-2:0], din};
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversamples SCLK/CS/MOSI, shifts a latched TX word out on MISO, assembles the RX word.
// Latency: pin edge to action is SYNC_STAGES+1 GCLK; rx_valid_o coincides with the mosi_data_o update.
// Backpressure: none; the master paces the frame and must respect the 4-GCLK half-period/setup/hold limits.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   DATA_W      = 32,
  parameter logic MISO_IDLE   = 1'b0
) (
  input  logic              GCLK,
  input  logic              RST,
  input  logic [1:0]        spi_mode_i,
  input  logic [1:0]        word_len_i,
  input  logic [DATA_W-1:0] miso_data_i,
  output logic [DATA_W-1:0] mosi_data_o,
  output logic              rx_valid_o,
  output logic              tx_load_o,
  output logic              frame_err_o,
  output logic              busy_o,
  input  logic              SCLK_i,
  input  logic              CS_i,
  input  logic              MOSI_i,
  output logic              MISO_o
);

  logic sclk_s, cs_s, mosi_s;
  logic sclk_q, cs_q;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .GCLK(GCLK), .RST(RST), .din(SCLK_i), .dout(sclk_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .GCLK(GCLK), .RST(RST), .din(CS_i), .dout(cs_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .GCLK(GCLK), .RST(RST), .din(MOSI_i), .dout(mosi_s));

  state_t            state_q, state_d;
  logic [3:0]        prime_q;
  logic [1:0]        mode_q;
  logic [5:0]        len_n_q;
  logic [5:0]        bit_cnt_q;
  logic [DATA_W-1:0] tx_sr_q;
  logic [DATA_W-1:0] rx_sr_q;
  logic              miso_q;

  logic primed, cpol, cpha;
  logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_rise, last_bit;
  logic do_load, do_sample, do_shift, do_done, do_err;
  logic [DATA_W-1:0] rx_next, tx_align;

  // The synchronizer outputs hold reset values for SYNC_STAGES cycles after reset;
  // IDLE_ARM must not trust cs_s until real pin data has flushed through.
  assign primed = (prime_q == 4'(SYNC_STAGES));

  assign cpol        = mode_q[MODE_CPOL];
  assign cpha        = mode_q[MODE_CPHA];
  assign sclk_edge   = sclk_s ^ sclk_q;
  assign lead_edge   = sclk_edge & (sclk_q == cpol);
  assign trail_edge  = sclk_edge & (sclk_s == cpol);
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge  : trail_edge;
  assign cs_fall     = cs_q & ~cs_s;
  assign cs_rise     = ~cs_q & cs_s;
  assign last_bit    = (bit_cnt_q == (len_n_q - 6'd1));
  assign rx_next     = {rx_sr_q[DATA_W-2:0], mosi_s};
  // TX word left-aligned so the bit to send next is always the MSB of the shift register
  assign tx_align    = miso_data_i << (6'(DATA_W) - len_bits(word_len_i));

  assign busy_o = ~cs_s & (state_q != IDLE_ARM);
  assign MISO_o = ((state_q == SHIFT) || (state_q == HOLD)) ? miso_q : MISO_IDLE;

  // state register and post-reset priming counter
  always_ff @(posedge GCLK) begin
    if (RST) begin
      state_q <= IDLE_ARM;
      prime_q <= '0;
    end else begin
      state_q <= state_d;
      if (!primed) prime_q <= prime_q + 4'd1;
    end
  end

  // next state and datapath strobes; a completing sample wins over a same-cycle CS rise
  always_comb begin
    state_d   = state_q;
    do_load   = 1'b0;
    do_sample = 1'b0;
    do_shift  = 1'b0;
    do_done   = 1'b0;
    do_err    = 1'b0;
    case (state_q)
      IDLE_ARM: begin
        if (primed && cs_s) state_d = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          do_load = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sample_edge && last_bit) begin
          do_sample = 1'b1;
          do_done   = 1'b1;
          state_d   = cs_rise ? IDLE : HOLD;
        end else if (cs_rise) begin
          do_err  = 1'b1;
          state_d = IDLE;
        end else begin
          do_sample = sample_edge;
          do_shift  = shift_edge;
        end
      end
      HOLD: begin
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = IDLE_ARM;
    endcase
  end

  // edge-detect history, frame configuration, shift registers and output pulses
  always_ff @(posedge GCLK) begin
    if (RST) begin
      sclk_q      <= 1'b0;
      cs_q        <= 1'b1;
      mode_q      <= '0;
      len_n_q     <= 6'd8;
      bit_cnt_q   <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      miso_q      <= MISO_IDLE;
      mosi_data_o <= '0;
      rx_valid_o  <= 1'b0;
      tx_load_o   <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      sclk_q      <= sclk_s;
      cs_q        <= cs_s;
      tx_load_o   <= do_load;
      rx_valid_o  <= do_done;
      frame_err_o <= do_err;
      if (do_load) begin
        mode_q    <= spi_mode_i;
        len_n_q   <= len_bits(word_len_i);
        bit_cnt_q <= '0;
        rx_sr_q   <= '0;
        // CPHA=0 presents the first bit before any SCLK edge; CPHA=1 waits for the first leading edge
        if (spi_mode_i[MODE_CPHA]) begin
          tx_sr_q <= tx_align;
          miso_q  <= MISO_IDLE;
        end else begin
          tx_sr_q <= tx_align << 1;
          miso_q  <= tx_align[DATA_W-1];
        end
      end
      if (do_sample) begin
        rx_sr_q   <= rx_next;
        bit_cnt_q <= bit_cnt_q + 6'd1;
      end
      if (do_done) mosi_data_o <= rx_next;
      if (do_shift) begin
        miso_q  <= tx_sr_q[DATA_W-1];
        tx_sr_q <= tx_sr_q << 1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: drives the SPI pins as a master, checks words and pulses.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_slave;

  localparam int H = 4;  // SCLK half-period in GCLK cycles

  logic        GCLK = 1'b0;
  logic        RST;
  logic [1:0]  spi_mode_i;
  logic [1:0]  word_len_i;
  logic [31:0] miso_data_i;
  logic [31:0] mosi_data_o;
  logic        rx_valid_o, tx_load_o, frame_err_o, busy_o;
  logic        SCLK_i, CS_i, MOSI_i, MISO_o;

  int n_checks = 0;
  int n_errors = 0;
  int rxv_n = 0, txl_n = 0, err_n = 0;

  spi_slave dut (
    .GCLK(GCLK), .RST(RST),
    .spi_mode_i(spi_mode_i), .word_len_i(word_len_i), .miso_data_i(miso_data_i),
    .mosi_data_o(mosi_data_o), .rx_valid_o(rx_valid_o), .tx_load_o(tx_load_o),
    .frame_err_o(frame_err_o), .busy_o(busy_o),
    .SCLK_i(SCLK_i), .CS_i(CS_i), .MOSI_i(MOSI_i), .MISO_o(MISO_o)
  );

  always #5 GCLK = ~GCLK;

  // count cycles each pulse output is high (a 2-cycle pulse counts twice)
  always @(negedge GCLK) begin
    if (rx_valid_o)  rxv_n++;
    if (tx_load_o)   txl_n++;
    if (frame_err_o) err_n++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // idle SCLK at CPOL, present config, drop CS, then scramble config mid-frame
  task automatic cs_begin(input logic [1:0] mode, input logic [1:0] wl, input logic [31:0] tx, input int setup);
    SCLK_i      = mode[1];
    spi_mode_i  = mode;
    word_len_i  = wl;
    miso_data_i = tx;
    repeat (setup) @(negedge GCLK);
    CS_i = 1'b0;
    repeat (6) @(negedge GCLK);
    miso_data_i = ~tx;
    word_len_i  = ~wl;
    spi_mode_i  = ~mode;
  endtask

  // nclk SCLK cycles; first n carry mosi_w MSB first and capture MISO, extras send 1s
  task automatic clk_bits(input logic [1:0] mode, input logic [31:0] mosi_w, input int n,
                          input int nclk, output logic [31:0] rx);
    rx = '0;
    for (int k = 0; k < nclk; k++) begin
      MOSI_i = (k < n) ? mosi_w[n-1-k] : 1'b1;
      if (!mode[0]) begin
        repeat (H) @(negedge GCLK);
        if (k < n) rx = {rx[30:0], MISO_o};
        SCLK_i = ~mode[1];
        repeat (H) @(negedge GCLK);
        SCLK_i = mode[1];
      end else begin
        SCLK_i = ~mode[1];
        repeat (H) @(negedge GCLK);
        if (k < n) rx = {rx[30:0], MISO_o};
        SCLK_i = mode[1];
        repeat (H) @(negedge GCLK);
      end
    end
  endtask

  task automatic cs_end(input int gap);
    repeat (5) @(negedge GCLK);
    CS_i = 1'b1;
    repeat (gap) @(negedge GCLK);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rx;
    int s_rxv, s_txl, s_err;
    logic [1:0] m;

    RST = 1'b1; CS_i = 1'b1; SCLK_i = 1'b0; MOSI_i = 1'b0;
    spi_mode_i = 2'b00; word_len_i = 2'b00; miso_data_i = '0;
    repeat (3) @(negedge GCLK);
    check_val("rst_mosi_data", mosi_data_o, 32'h0);
    check_val("rst_rx_valid",  32'(rx_valid_o), 32'h0);
    check_val("rst_tx_load",   32'(tx_load_o), 32'h0);
    check_val("rst_frame_err", 32'(frame_err_o), 32'h0);
    check_val("rst_busy",      32'(busy_o), 32'h0);
    check_val("rst_miso",      32'(MISO_o), 32'h0);
    RST = 1'b0;
    repeat (10) @(negedge GCLK);

    // 1: mode 0, 8 bits
    s_rxv = rxv_n; s_txl = txl_n; s_err = err_n;
    cs_begin(2'b00, 2'b00, 32'h000000A5, 4);
    check_val("t1_busy_mid", 32'(busy_o), 32'h1);
    clk_bits(2'b00, 32'h3C, 8, 8, rx);
    cs_end(6);
    check_val("t1_tx_load_cnt", 32'(txl_n - s_txl), 32'd1);
    check_val("t1_rx_valid_cnt", 32'(rxv_n - s_rxv), 32'd1);
    check_val("t1_mosi_data", mosi_data_o, 32'h0000003C);
    check_val("t1_master_rx", rx, 32'h000000A5);
    check_val("t1_no_err", 32'(err_n - s_err), 32'd0);

    // 2: modes 1..3, 32 bits
    for (int i = 1; i < 4; i++) begin
      m = 2'(i);
      s_rxv = rxv_n; s_err = err_n;
      cs_begin(m, 2'b11, 32'hDEADBEEF, 4);
      clk_bits(m, 32'h12345678, 32, 32, rx);
      cs_end(6);
      check_val($sformatf("t2_m%0d_mosi_data", i), mosi_data_o, 32'h12345678);
      check_val($sformatf("t2_m%0d_master_rx", i), rx, 32'hDEADBEEF);
      check_val($sformatf("t2_m%0d_rx_valid_cnt", i), 32'(rxv_n - s_rxv), 32'd1);
      check_val($sformatf("t2_m%0d_no_err", i), 32'(err_n - s_err), 32'd0);
    end

    // 3: mode 0, 16 bits, CS released after 9 clocks
    s_rxv = rxv_n; s_err = err_n;
    cs_begin(2'b00, 2'b01, 32'h0000BEEF, 4);
    clk_bits(2'b00, 32'h0000A55A, 16, 9, rx);
    cs_end(6);
    check_val("t3_err_cnt", 32'(err_n - s_err), 32'd1);
    check_val("t3_no_rx_valid", 32'(rxv_n - s_rxv), 32'd0);
    check_val("t3_mosi_kept", mosi_data_o, 32'h12345678);
    check_val("t3_busy_low", 32'(busy_o), 32'h0);
    check_val("t3_miso_idle", 32'(MISO_o), 32'h0);

    // 4: 8-bit frame with 12 SCLK cycles
    s_rxv = rxv_n; s_err = err_n;
    cs_begin(2'b00, 2'b00, 32'h0000005B, 4);
    clk_bits(2'b00, 32'h96, 8, 12, rx);
    check_val("t4_miso_held", 32'(MISO_o), 32'h1);
    cs_end(6);
    check_val("t4_rx_valid_cnt", 32'(rxv_n - s_rxv), 32'd1);
    check_val("t4_mosi_data", mosi_data_o, 32'h00000096);
    check_val("t4_master_rx", rx, 32'h0000005B);
    check_val("t4_no_err", 32'(err_n - s_err), 32'd0);

    // 5: reset mid 24-bit frame with CS still low
    cs_begin(2'b00, 2'b10, 32'h00C3A55A, 4);
    clk_bits(2'b00, 32'h001E2D3C, 24, 5, rx);
    RST = 1'b1;
    @(negedge GCLK);
    RST = 1'b0;
    s_rxv = rxv_n; s_txl = txl_n; s_err = err_n;
    repeat (2) @(negedge GCLK);
    check_val("t5_busy_after_rst", 32'(busy_o), 32'h0);
    check_val("t5_mosi_after_rst", mosi_data_o, 32'h0);
    check_val("t5_miso_after_rst", 32'(MISO_o), 32'h0);
    clk_bits(2'b00, 32'h0, 24, 3, rx);
    check_val("t5_busy_cs_low", 32'(busy_o), 32'h0);
    cs_end(6);
    check_val("t5_no_pulses", 32'((rxv_n - s_rxv) + (txl_n - s_txl) + (err_n - s_err)), 32'd0);
    cs_begin(2'b00, 2'b10, 32'h00C3A55A, 4);
    clk_bits(2'b00, 32'h001E2D3C, 24, 24, rx);
    cs_end(6);
    check_val("t5_mosi_data", mosi_data_o, 32'h001E2D3C);
    check_val("t5_master_rx", rx, 32'h00C3A55A);

    // 6: back-to-back 24-bit frames, modes 0 then 3, 4-GCLK CS-high gap
    s_rxv = rxv_n; s_err = err_n;
    cs_begin(2'b00, 2'b10, 32'hFF13579B, 4);
    clk_bits(2'b00, 32'h00ABCDEF, 24, 24, rx);
    cs_end(0);
    check_val("t6a_mosi_data", mosi_data_o, 32'h00ABCDEF);
    check_val("t6a_master_rx", rx, 32'h0013579B);
    cs_begin(2'b11, 2'b10, 32'h002468AC, 4);
    clk_bits(2'b11, 32'h000F1E2D, 24, 24, rx);
    cs_end(6);
    check_val("t6b_mosi_data", mosi_data_o, 32'h000F1E2D);
    check_val("t6b_master_rx", rx, 32'h002468AC);
    check_val("t6_rx_valid_cnt", 32'(rxv_n - s_rxv), 32'd2);
    check_val("t6_no_err", 32'(err_n - s_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
